// File: rtl/wb_pipe_stage_pkg.sv
// rtl/wb_pipe_stage_pkg.sv - shared defines for the MEM->WB elastic stage
package wb_pipe_stage_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Source selection for the main (output) register
  localparam logic [1:0] SEL_HOLD = 2'd0;
  localparam logic [1:0] SEL_IN   = 2'd1;
  localparam logic [1:0] SEL_SKID = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  localparam logic [31:0] ZeroWord           = 32'h0000_0000;
  localparam logic [4:0]  NOPRegisterAddress = 5'b00000;
  localparam logic        WriteEnable        = 1'b1;
  localparam logic        WriteDisable       = 1'b0;

  localparam int MAX_NUM_CH = 4;

endpackage

// File: rtl/wb_chan_filter.sv
// rtl/wb_chan_filter.sv - clears writes to $0 and all but the highest channel per destination
module wb_chan_filter
  import wb_pipe_stage_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int ADDR_W = 5
) (
  input  logic [NUM_CH*ADDR_W-1:0] i_wd,
  input  logic [NUM_CH-1:0]        i_wreg,
  output logic [NUM_CH-1:0]        o_wreg
);

  always_comb begin
    o_wreg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_wreg[i] && (i_wd[i*ADDR_W +: ADDR_W] != '0)) begin
        o_wreg[i] = WriteEnable;
      end
      // A later channel writing the same register supersedes this one
      for (int j = i + 1; j < NUM_CH; j++) begin
        if (i_wreg[j] && (i_wd[j*ADDR_W +: ADDR_W] == i_wd[i*ADDR_W +: ADDR_W])) begin
          o_wreg[i] = WriteDisable;
        end
      end
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// rtl/wb_pipe_stage.sv - MEM->WB valid/ready stage with 2-entry skid buffer
// Optional hi/lo payload compiled in with HILO_EN.
module wb_pipe_stage
  import wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [NUM_CH*ADDR_W-1:0] mem_wd,
  input  logic [NUM_CH-1:0]        mem_wreg,
  input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
`ifdef HILO_EN
  input  logic                     mem_whilo,
  input  logic [DATA_W-1:0]        mem_hi,
  input  logic [DATA_W-1:0]        mem_lo,
  output logic                     wb_whilo,
  output logic [DATA_W-1:0]        wb_hi,
  output logic [DATA_W-1:0]        wb_lo,
`endif
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [NUM_CH*ADDR_W-1:0] wb_wd,
  output logic [NUM_CH-1:0]        wb_wreg,
  output logic [NUM_CH*DATA_W-1:0] wb_wdata
);

  if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("wb_pipe_stage: NUM_CH out of range");
  end

  logic [1:0]               r_state;
  logic [NUM_CH*ADDR_W-1:0] r_main_wd, r_skid_wd;
  logic [NUM_CH-1:0]        r_main_wreg, r_skid_wreg;
  logic [NUM_CH*DATA_W-1:0] r_main_wdata, r_skid_wdata;
`ifdef HILO_EN
  logic                     r_main_whilo, r_skid_whilo;
  logic [DATA_W-1:0]        r_main_hi, r_main_lo, r_skid_hi, r_skid_lo;
`endif

  logic              w_accept;
  logic              w_drain;
  logic [NUM_CH-1:0] w_flt_wreg;
  logic [1:0]        w_state_nxt;
  logic [1:0]        w_main_sel;
  logic              w_skid_load;
  logic              w_skid_clr;

  wb_chan_filter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) u_chan_filter (
    .i_wd   (mem_wd),
    .i_wreg (mem_wreg),
    .o_wreg (w_flt_wreg)
  );

  // Ready depends on state only, so wb_ready never reaches mem_ready combinationally
  assign mem_ready = (r_state != ST_FULL);
  assign wb_valid  = (r_state != ST_EMPTY);
  assign w_accept  = mem_valid & mem_ready;
  assign w_drain   = wb_valid & wb_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_sel  = SEL_HOLD;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_sel  = SEL_ZERO;
      w_skid_clr  = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_main_sel  = SEL_IN;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_main_sel  = SEL_IN;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_skid_load = 1'b1;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
            w_main_sel  = SEL_ZERO;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_state_nxt = ST_ONE;
            w_main_sel  = SEL_SKID;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_sel  = SEL_ZERO;
          w_skid_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_main_wd    <= '0;
      r_main_wreg  <= '0;
      r_main_wdata <= '0;
      r_skid_wd    <= '0;
      r_skid_wreg  <= '0;
      r_skid_wdata <= '0;
`ifdef HILO_EN
      r_main_whilo <= 1'b0;
      r_main_hi    <= '0;
      r_main_lo    <= '0;
      r_skid_whilo <= 1'b0;
      r_skid_hi    <= '0;
      r_skid_lo    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (w_main_sel)
        SEL_IN: begin
          r_main_wd    <= mem_wd;
          r_main_wreg  <= w_flt_wreg;
          r_main_wdata <= mem_wdata;
`ifdef HILO_EN
          r_main_whilo <= mem_whilo;
          r_main_hi    <= mem_hi;
          r_main_lo    <= mem_lo;
`endif
        end
        SEL_SKID: begin
          r_main_wd    <= r_skid_wd;
          r_main_wreg  <= r_skid_wreg;
          r_main_wdata <= r_skid_wdata;
`ifdef HILO_EN
          r_main_whilo <= r_skid_whilo;
          r_main_hi    <= r_skid_hi;
          r_main_lo    <= r_skid_lo;
`endif
        end
        SEL_ZERO: begin
          r_main_wd    <= '0;
          r_main_wreg  <= '0;
          r_main_wdata <= '0;
`ifdef HILO_EN
          r_main_whilo <= 1'b0;
          r_main_hi    <= '0;
          r_main_lo    <= '0;
`endif
        end
        default: begin
        end
      endcase
      if (w_skid_clr) begin
        r_skid_wd    <= '0;
        r_skid_wreg  <= '0;
        r_skid_wdata <= '0;
`ifdef HILO_EN
        r_skid_whilo <= 1'b0;
        r_skid_hi    <= '0;
        r_skid_lo    <= '0;
`endif
      end else if (w_skid_load) begin
        r_skid_wd    <= mem_wd;
        r_skid_wreg  <= w_flt_wreg;
        r_skid_wdata <= mem_wdata;
`ifdef HILO_EN
        r_skid_whilo <= mem_whilo;
        r_skid_hi    <= mem_hi;
        r_skid_lo    <= mem_lo;
`endif
      end
    end
  end

  assign wb_wd    = r_main_wd;
  assign wb_wreg  = r_main_wreg;
  assign wb_wdata = r_main_wdata;
`ifdef HILO_EN
  assign wb_whilo = r_main_whilo;
  assign wb_hi    = r_main_hi;
  assign wb_lo    = r_main_lo;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// tb/tb_wb_pipe_stage.sv - self-checking bench for wb_pipe_stage (NUM_CH = 2)
module tb_wb_pipe_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NC = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, flush, mem_valid, mem_ready, wb_valid, wb_ready;
  logic [NC*AW-1:0] mem_wd, wb_wd;
  logic [NC-1:0]    mem_wreg, wb_wreg;
  logic [NC*DW-1:0] mem_wdata, wb_wdata;
  logic             mem_whilo, wb_whilo;
  logic [DW-1:0]    mem_hi, mem_lo, wb_hi, wb_lo;

  wb_pipe_stage #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
`ifdef HILO_EN
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .wb_whilo  (wb_whilo),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
`endif
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata)
  );

`ifndef HILO_EN
  assign wb_whilo = 1'b0;
  assign wb_hi    = '0;
  assign wb_lo    = '0;
`endif

  typedef struct {
    logic [NC*AW-1:0] wd;
    logic [NC-1:0]    wreg;
    logic [NC*DW-1:0] wdata;
    logic [NC-1:0]    exp_wreg;
    logic             whilo;
    logic [DW-1:0]    hi;
    logic [DW-1:0]    lo;
  } vec_t;

  typedef struct {
    logic [NC*AW-1:0] wd;
    logic [NC-1:0]    wreg;
    logic [NC*DW-1:0] wdata;
    logic             whilo;
    logic [DW-1:0]    hi;
    logic [DW-1:0]    lo;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  logic [NC-1:0] cur_exp_wreg;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] wd0, input logic [4:0] wd1,
                              input logic [1:0] wreg, input logic [1:0] exp_wreg,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic wh, input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.wd = {wd1, wd0};
    v.wreg = wreg;
    v.wdata = {d1, d0};
    v.exp_wreg = exp_wreg;
    v.whilo = wh;
    v.hi = hi;
    v.lo = lo;
    return v;
  endfunction

  // Scoreboard: entries pushed on accept, popped and compared on drain
  always @(negedge clock) begin
    if (mon_en) begin
      if (reset || flush) begin
        sb.delete();
      end else begin
        if (wb_valid && wb_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain_unexpected actual=entry wd=%0h required=no entry", wb_wd);
          end else begin
            mon_e = sb.pop_front();
            chk("drain_wd", 64'(wb_wd), 64'(mon_e.wd));
            chk("drain_wreg", 64'(wb_wreg), 64'(mon_e.wreg));
            chk("drain_wdata", wb_wdata, mon_e.wdata);
`ifdef HILO_EN
            chk("drain_whilo", 64'(wb_whilo), 64'(mon_e.whilo));
            chk("drain_hi", 64'(wb_hi), 64'(mon_e.hi));
            chk("drain_lo", 64'(wb_lo), 64'(mon_e.lo));
`endif
          end
        end
        if (mem_valid && mem_ready) begin
          mon_e.wd = mem_wd;
          mon_e.wreg = cur_exp_wreg;
          mon_e.wdata = mem_wdata;
          mon_e.whilo = mem_whilo;
          mon_e.hi = mem_hi;
          mon_e.lo = mem_lo;
          sb.push_back(mon_e);
        end
      end
      if (!wb_valid) chk("idle_wreg_zero", 64'(wb_wreg), 64'd0);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_in(input vec_t v);
    mem_wd = v.wd;
    mem_wreg = v.wreg;
    mem_wdata = v.wdata;
    mem_whilo = v.whilo;
    mem_hi = v.hi;
    mem_lo = v.lo;
    cur_exp_wreg = v.exp_wreg;
    mem_valid = 1'b1;
  endtask

  // Presents v and returns one cycle after it has been accepted
  task automatic send(input vec_t v);
    int n;
    set_in(v);
    n = 0;
    while (!mem_ready && n < 50) begin
      cycles(1);
      n++;
    end
    checks++;
    if (!mem_ready) begin
      errors++;
      $display("FAIL send_timeout actual=mem_ready low for %0d cycles required=accept", n);
    end
    cycles(1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_wd"}, 64'(wb_wd), 64'd0);
    chk({tag, "_wreg"}, 64'(wb_wreg), 64'd0);
    chk({tag, "_wdata"}, wb_wdata, 64'd0);
    chk({tag, "_ready"}, 64'(mem_ready), 64'd1);
`ifdef HILO_EN
    chk({tag, "_whilo"}, 64'(wb_whilo), 64'd0);
    chk({tag, "_hi"}, 64'(wb_hi), 64'd0);
    chk({tag, "_lo"}, 64'(wb_lo), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //               wd0  wd1  wreg   exp    d0            d1            whilo hi lo
    vecs[0] = mk(5'd3,  5'd0, 2'b01, 2'b01, 32'h11,       32'h0,        1'b0, 0, 0);
    vecs[1] = mk(5'd7,  5'd7, 2'b11, 2'b10, 32'hAAAA0001, 32'hBBBB0002, 1'b0, 0, 0);
    vecs[2] = mk(5'd0,  5'd4, 2'b11, 2'b10, 32'h12345678, 32'h9ABCDEF0, 1'b0, 0, 0);
    vecs[3] = mk(5'd5,  5'd6, 2'b11, 2'b11, 32'h00000055, 32'h00000066, 1'b0, 0, 0);
    vecs[4] = mk(5'd9,  5'd9, 2'b10, 2'b10, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 0, 0);
    vecs[5] = mk(5'd9,  5'd9, 2'b01, 2'b01, 32'h01010101, 32'h02020202, 1'b0, 0, 0);
    vecs[6] = mk(5'd0,  5'd0, 2'b11, 2'b00, 32'hFFFFFFFF, 32'hEEEEEEEE, 1'b0, 0, 0);
    vecs[7] = mk(5'd31, 5'd1, 2'b11, 2'b11, 32'h80000000, 32'h00000001, 1'b0, 0, 0);

    reset = 1'b1; flush = 1'b0; mem_valid = 1'b0; wb_ready = 1'b0;
    mem_wd = '0; mem_wreg = '0; mem_wdata = '0; mem_whilo = 1'b0; mem_hi = '0; mem_lo = '0;
    cur_exp_wreg = '0;
    cycles(3);
    reset = 1'b0;
    mon_en = 1'b1;
    chk_all_zero("reset");

    // Streaming at full rate
    wb_ready = 1'b1;
    send(vecs[0]);
    chk("lat_valid", 64'(wb_valid), 64'd1);
    chk("lat_wd", 64'(wb_wd), 64'(vecs[0].wd));
    chk("lat_wdata", wb_wdata, vecs[0].wdata);
    for (int i = 1; i < 8; i++) begin
      chk("stream_ready", 64'(mem_ready), 64'd1);
      send(vecs[i]);
    end
    mem_valid = 1'b0;
    cycles(3);
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Back-pressure: A in main, B in skid, C held off
    wb_ready = 1'b0;
    send(vecs[3]);
    send(vecs[4]);
    set_in(vecs[7]);
    chk("bp_ready_low", 64'(mem_ready), 64'd0);
    chk("bp_valid", 64'(wb_valid), 64'd1);
    chk("bp_head_wd", 64'(wb_wd), 64'(vecs[3].wd));
    cycles(2);
    chk("bp_hold_ready", 64'(mem_ready), 64'd0);
    chk("bp_hold_head", wb_wdata, vecs[3].wdata);
    wb_ready = 1'b1;
    send(vecs[7]);
    mem_valid = 1'b0;
    cycles(3);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);
    chk("bp_end_valid", 64'(wb_valid), 64'd0);

    // Flush while FULL with an entry presented
    wb_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    set_in(vecs[5]);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    mem_valid = 1'b0;
    chk_all_zero("flush_full");
    wb_ready = 1'b1;
    cycles(3);
    chk("flush_full_gone", 64'(wb_valid), 64'd0);

    // Flush in ONE discards a simultaneous accept
    wb_ready = 1'b0;
    send(vecs[3]);
    set_in(vecs[4]);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    mem_valid = 1'b0;
    chk_all_zero("flush_one");
    wb_ready = 1'b1;
    cycles(3);
    chk("flush_one_gone", 64'(wb_valid), 64'd0);

    // Reset mid-stream under back-pressure
    wb_ready = 1'b0;
    send(vecs[5]);
    send(vecs[7]);
    set_in(vecs[1]);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    mem_valid = 1'b0;
    chk_all_zero("mid_reset");
    wb_ready = 1'b1;
    cycles(2);
    chk("mid_reset_gone", 64'(wb_valid), 64'd0);

`ifdef HILO_EN
    // hi/lo carried through the skid register
    wb_ready = 1'b0;
    send(mk(5'd2, 5'd3, 2'b11, 2'b11, 32'h2, 32'h3, 1'b0, 32'h1, 32'h2));
    send(mk(5'd4, 5'd5, 2'b01, 2'b01, 32'h4, 32'h5, 1'b1, 32'hDEAD, 32'hBEEF));
    mem_valid = 1'b0;
    chk("hilo_main_whilo", 64'(wb_whilo), 64'd0);
    wb_ready = 1'b1;
    cycles(1);
    chk("hilo_skid_whilo", 64'(wb_whilo), 64'd1);
    chk("hilo_skid_hi", 64'(wb_hi), 64'hDEAD);
    chk("hilo_skid_lo", 64'(wb_lo), 64'hBEEF);
    cycles(1);
    chk("hilo_empty_whilo", 64'(wb_whilo), 64'd0);
    chk("hilo_empty_valid", 64'(wb_valid), 64'd0);
`endif

    cycles(2);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
